// File: rtl/eq_check_pkg.sv
// Shared types, default widths and the saturating-increment helper
// for the equality-comparator result checker.
package eq_check_pkg;

  typedef enum logic [1:0] {
    WARM   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int DEF_W     = 16;
  localparam int DEF_CNT_W = 32;
  // Widest counter the helper supports.
  localparam int MAX_CNT_W = 64;

  // Increment v by one unless it already holds the all-ones value of a
  // w-bit counter; the caller zero-extends into, and truncates from, 64 bits.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                   input int unsigned w);
    logic [MAX_CNT_W-1:0] lim;
    lim = (w >= MAX_CNT_W) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
  import eq_check_pkg::*;
#(
  parameter int WIDTH = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear wins, otherwise saturating increment.
  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc)
      count_d = WIDTH'(sat_inc(MAX_CNT_W'(count_q), WIDTH));
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/eq_result_checker.sv
// Downstream checker for the 16-bit equality comparator: recomputes a==b,
// keeps saturating statistics, captures the first failing beat and can halt
// the stream. Optional feature macro: EQ_CHECK_RUNLEN_EN adds run_len and
// max_run_len outputs tracking consecutive golden-equal checked beats.
module eq_result_checker
  import eq_check_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WARMUP      = 2,
  parameter int HALT_ON_ERR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_eq,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [W-1:0]     first_err_a,
  output logic [W-1:0]     first_err_b,
  output logic             first_err_got,
  output logic             halted
`ifdef EQ_CHECK_RUNLEN_EN
  ,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] max_run_len
`endif
);

  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  state_t              state_q, state_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic                err_flag_q;
  logic [W-1:0]        fa_q, fb_q;
  logic                fg_q;

  logic golden, chk, mismatch;

  // Ready never looks at in_valid; reset and clear both block acceptance.
  assign in_ready = rst_n && (state_q != HALTED) && !clear;
  assign golden   = (in_a == in_b);
  assign chk      = in_valid && in_ready && (state_q == RUN);
  assign mismatch = (in_eq != golden);

  // Next-state: warm-up count, run, and halting on a disagreement.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    if (clear) begin
      state_d = WARM;
      warm_d  = '0;
    end else begin
      case (state_q)
        WARM: begin
          if (WARMUP <= 1 || warm_q == WARM_W'(WARMUP - 1)) begin
            state_d = RUN;
            warm_d  = '0;
          end else begin
            warm_d = warm_q + WARM_W'(1);
          end
        end
        RUN:     if (chk && mismatch && (HALT_ON_ERR != 0)) state_d = HALTED;
        HALTED:  state_d = HALTED;
        default: state_d = WARM;
      endcase
    end
  end

  // FSM and warm-up counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WARM;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  // Sticky error flag and first-failure capture; only the first error loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag_q <= 1'b0;
      fa_q       <= '0;
      fb_q       <= '0;
      fg_q       <= 1'b0;
    end else if (clear) begin
      err_flag_q <= 1'b0;
      fa_q       <= '0;
      fb_q       <= '0;
      fg_q       <= 1'b0;
    end else if (chk && mismatch && !err_flag_q) begin
      err_flag_q <= 1'b1;
      fa_q       <= in_a;
      fb_q       <= in_b;
      fg_q       <= in_eq;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_sample (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(chk), .count(sample_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_eq (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(chk && golden), .count(eq_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_err (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(chk && mismatch), .count(err_cnt)
  );

`ifdef EQ_CHECK_RUNLEN_EN
  logic run_inc, run_clr, max_inc;

  // run_len never exceeds max_run_len, so the maximum only moves when
  // the current run is already at it and grows by one.
  assign run_inc = chk && golden;
  assign run_clr = clear || (chk && !golden);
  assign max_inc = run_inc && (run_len == max_run_len);

  sat_counter #(.WIDTH(CNT_W)) u_run (
    .clk(clk), .rst_n(rst_n), .clr(run_clr), .inc(run_inc), .count(run_len)
  );

  sat_counter #(.WIDTH(CNT_W)) u_max (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(max_inc), .count(max_run_len)
  );
`endif

  assign err_flag      = err_flag_q;
  assign first_err_a   = fa_q;
  assign first_err_b   = fb_q;
  assign first_err_got = fg_q;
  assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_eq_result_checker.sv
// Self-checking bench: three checker instances (halting, non-halting,
// 4-bit counters) share one randomized stream and are compared every cycle
// against a behavioural model, plus literal expectations at key points.
module tb_eq_result_checker;

  localparam int WUP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_eq = 1'b0;
  bit          go = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 0: halt on error; 1: keep running; 2: 4-bit counters, halting.
  logic [31:0] s0_samp, s0_eq, s0_err, s1_samp, s1_eq, s1_err;
  logic [3:0]  s2_samp, s2_eq, s2_err;
  logic        s0_flag, s1_flag, s2_flag, s0_fg, s1_fg, s2_fg;
  logic        s0_halt, s1_halt, s2_halt, s0_rdy, s1_rdy, s2_rdy;
  logic [15:0] s0_fa, s0_fb, s1_fa, s1_fb, s2_fa, s2_fb;
`ifdef EQ_CHECK_RUNLEN_EN
  logic [31:0] s0_run, s0_max, s1_run, s1_max;
  logic [3:0]  s2_run, s2_max;
`endif

  eq_result_checker #(.W(16), .CNT_W(32), .WARMUP(WUP), .HALT_ON_ERR(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s0_rdy),
    .in_a(in_a), .in_b(in_b), .in_eq(in_eq), .sample_cnt(s0_samp), .eq_cnt(s0_eq),
    .err_cnt(s0_err), .err_flag(s0_flag), .first_err_a(s0_fa), .first_err_b(s0_fb),
    .first_err_got(s0_fg), .halted(s0_halt)
`ifdef EQ_CHECK_RUNLEN_EN
    , .run_len(s0_run), .max_run_len(s0_max)
`endif
  );

  eq_result_checker #(.W(16), .CNT_W(32), .WARMUP(WUP), .HALT_ON_ERR(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s1_rdy),
    .in_a(in_a), .in_b(in_b), .in_eq(in_eq), .sample_cnt(s1_samp), .eq_cnt(s1_eq),
    .err_cnt(s1_err), .err_flag(s1_flag), .first_err_a(s1_fa), .first_err_b(s1_fb),
    .first_err_got(s1_fg), .halted(s1_halt)
`ifdef EQ_CHECK_RUNLEN_EN
    , .run_len(s1_run), .max_run_len(s1_max)
`endif
  );

  eq_result_checker #(.W(16), .CNT_W(4), .WARMUP(WUP), .HALT_ON_ERR(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s2_rdy),
    .in_a(in_a), .in_b(in_b), .in_eq(in_eq), .sample_cnt(s2_samp), .eq_cnt(s2_eq),
    .err_cnt(s2_err), .err_flag(s2_flag), .first_err_a(s2_fa), .first_err_b(s2_fb),
    .first_err_got(s2_fg), .halted(s2_halt)
`ifdef EQ_CHECK_RUNLEN_EN
    , .run_len(s2_run), .max_run_len(s2_max)
`endif
  );

  // ---------------- behavioural model ----------------
  int     cw  [3] = '{32, 32, 4};
  bit     hoe [3] = '{1'b1, 1'b0, 1'b1};
  longint m_samp[3], m_eq[3], m_err[3], m_run[3], m_max[3];
  int     m_age[3];
  bit     m_flag[3], m_halt[3], m_fg[3];
  logic [15:0] m_fa[3], m_fb[3];

  function automatic longint sat1(input longint x, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (x < lim) ? x + 1 : x;
  endfunction

  // Model: cycles since reset/clear decide warm-up; halted freezes everything.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || clear) begin
        m_samp[i] <= 0; m_eq[i] <= 0; m_err[i] <= 0; m_run[i] <= 0; m_max[i] <= 0;
        m_age[i] <= 0; m_flag[i] <= 1'b0; m_halt[i] <= 1'b0;
        m_fa[i] <= '0; m_fb[i] <= '0; m_fg[i] <= 1'b0;
      end else if (m_halt[i]) begin
        m_age[i] <= m_age[i];
      end else if (m_age[i] < WUP) begin
        m_age[i] <= m_age[i] + 1;
      end else if (in_valid) begin
        m_samp[i] <= sat1(m_samp[i], cw[i]);
        if (in_a == in_b) begin
          m_eq[i]  <= sat1(m_eq[i], cw[i]);
          m_run[i] <= sat1(m_run[i], cw[i]);
          if (sat1(m_run[i], cw[i]) > m_max[i]) m_max[i] <= sat1(m_run[i], cw[i]);
        end else begin
          m_run[i] <= 0;
        end
        if (in_eq != (in_a == in_b)) begin
          m_err[i] <= sat1(m_err[i], cw[i]);
          if (!m_flag[i]) begin
            m_fa[i] <= in_a; m_fb[i] <= in_b; m_fg[i] <= in_eq;
          end
          m_flag[i] <= 1'b1;
          if (hoe[i]) m_halt[i] <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [63:0] samp, eqc, errc,
                          input logic flag, input logic [15:0] fa, fb,
                          input logic fg, halt, rdy, input logic [63:0] run, mx);
    chk($sformatf("i%0d.sample_cnt", i), samp, 64'(m_samp[i]));
    chk($sformatf("i%0d.eq_cnt", i), eqc, 64'(m_eq[i]));
    chk($sformatf("i%0d.err_cnt", i), errc, 64'(m_err[i]));
    chk($sformatf("i%0d.err_flag", i), 64'(flag), 64'(m_flag[i]));
    chk($sformatf("i%0d.first_err_a", i), 64'(fa), 64'(m_fa[i]));
    chk($sformatf("i%0d.first_err_b", i), 64'(fb), 64'(m_fb[i]));
    chk($sformatf("i%0d.first_err_got", i), 64'(fg), 64'(m_fg[i]));
    chk($sformatf("i%0d.halted", i), 64'(halt), 64'(m_halt[i]));
    chk($sformatf("i%0d.in_ready", i), 64'(rdy), 64'(rst_n && !m_halt[i] && !clear));
`ifdef EQ_CHECK_RUNLEN_EN
    chk($sformatf("i%0d.run_len", i), run, 64'(m_run[i]));
    chk($sformatf("i%0d.max_run_len", i), mx, 64'(m_max[i]));
`endif
  endtask

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (go) begin
`ifdef EQ_CHECK_RUNLEN_EN
      cmp_inst(0, 64'(s0_samp), 64'(s0_eq), 64'(s0_err), s0_flag, s0_fa, s0_fb, s0_fg,
               s0_halt, s0_rdy, 64'(s0_run), 64'(s0_max));
      cmp_inst(1, 64'(s1_samp), 64'(s1_eq), 64'(s1_err), s1_flag, s1_fa, s1_fb, s1_fg,
               s1_halt, s1_rdy, 64'(s1_run), 64'(s1_max));
      cmp_inst(2, 64'(s2_samp), 64'(s2_eq), 64'(s2_err), s2_flag, s2_fa, s2_fb, s2_fg,
               s2_halt, s2_rdy, 64'(s2_run), 64'(s2_max));
`else
      cmp_inst(0, 64'(s0_samp), 64'(s0_eq), 64'(s0_err), s0_flag, s0_fa, s0_fb, s0_fg,
               s0_halt, s0_rdy, 64'd0, 64'd0);
      cmp_inst(1, 64'(s1_samp), 64'(s1_eq), 64'(s1_err), s1_flag, s1_fa, s1_fb, s1_fg,
               s1_halt, s1_rdy, 64'd0, 64'd0);
      cmp_inst(2, 64'(s2_samp), 64'(s2_eq), 64'(s2_err), s2_flag, s2_fa, s2_fb, s2_fg,
               s2_halt, s2_rdy, 64'd0, 64'd0);
`endif
    end
  end

  // Present one cycle of inputs; returns just after the following falling edge.
  task automatic drive(input logic v, input logic [15:0] a, b, input logic e, input logic c);
    in_valid = v; in_a = a; in_b = b; in_eq = e; clear = c;
    @(negedge clk); #1;
  endtask

  task automatic good_beat(input bit equal);
    logic [15:0] a, b;
    a = 16'($urandom);
    b = equal ? a : (a ^ 16'($urandom_range(1, 65535)));
    drive(1'b1, a, b, (a == b), 1'b0);
  endtask

  int eqc;

  initial begin
    repeat (3) @(negedge clk);
    go = 1'b1;
    #1;
    // Reset state.
    chk("rst.sample_cnt", 64'(s0_samp), 64'd0);
    chk("rst.in_ready", 64'(s0_rdy), 64'd0);
    chk("rst.halted", 64'(s0_halt), 64'd0);
    chk("rst.err_flag", 64'(s0_flag), 64'd0);

    // Warm-up: two beats dropped, third checked.
    rst_n = 1'b1;
    good_beat(1'b1);
    good_beat(1'b0);
    chk("warm.sample_cnt", 64'(s0_samp), 64'd0);
    good_beat(1'b0);
    chk("warm.third_beat", 64'(s0_samp), 64'd1);

    // Clean stream of 1000 beats after a clear and warm-up.
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    eqc = 0;
    for (int k = 0; k < 1000; k++) begin
      bit e;
      e = ($urandom_range(0, 3) == 0);
      if (e) eqc++;
      good_beat(e);
    end
    chk("clean.sample_cnt", 64'(s0_samp), 64'd1000);
    chk("clean.eq_cnt", 64'(s0_eq), 64'(eqc));
    chk("clean.err_cnt", 64'(s0_err), 64'd0);
    chk("clean.err_flag", 64'(s0_flag), 64'd0);
    chk("sat.sample_cnt", 64'(s2_samp), 64'd15);

    // Injected error.
    drive(1'b1, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
    chk("inj.err_cnt", 64'(s0_err), 64'd1);
    chk("inj.first_err_a", 64'(s0_fa), 64'h00FF);
    chk("inj.first_err_got", 64'(s0_fg), 64'd0);
    chk("inj.halted", 64'(s0_halt), 64'd1);
    chk("inj.in_ready", 64'(s0_rdy), 64'd0);

    // Two more errors: the non-halting instance keeps the first capture.
    drive(1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0);
    drive(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("nohalt.err_cnt", 64'(s1_err), 64'd3);
    chk("nohalt.first_err_a", 64'(s1_fa), 64'h00FF);
    chk("nohalt.first_err_b", 64'(s1_fb), 64'h00FF);
    chk("halt.err_cnt_frozen", 64'(s0_err), 64'd1);

    // Clear together with a valid beat: beat dropped, everything zero.
    drive(1'b1, 16'h0007, 16'h0007, 1'b1, 1'b1);
    chk("clr.sample_cnt", 64'(s0_samp), 64'd0);
    chk("clr.halted", 64'(s0_halt), 64'd0);
    chk("clr.err_cnt1", 64'(s1_err), 64'd0);
    chk("clr.err_flag1", 64'(s1_flag), 64'd0);
    chk("clr.first_err_a1", 64'(s1_fa), 64'd0);

    // Run-length pattern: 5 equal, 1 unequal, 3 equal.
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (5) good_beat(1'b1);
    good_beat(1'b0);
    repeat (3) good_beat(1'b1);
    chk("runpat.eq_cnt", 64'(s0_eq), 64'd8);
`ifdef EQ_CHECK_RUNLEN_EN
    chk("runpat.run_len", 64'(s0_run), 64'd3);
    chk("runpat.max_run_len", 64'(s0_max), 64'd5);
`endif

    // Random traffic with occasional errors, clears and a mid-stream reset.
    for (int k = 0; k < 400; k++) begin
      logic [15:0] a, b;
      logic e;
      a = 16'($urandom);
      b = ($urandom_range(0, 9) < 3) ? a : 16'($urandom);
      e = (a == b);
      if ($urandom_range(0, 19) == 0) e = ~e;
      if (k == 200) rst_n = 1'b0;
      drive(($urandom_range(0, 9) < 8), a, b, e, ($urandom_range(0, 49) == 0));
      rst_n = 1'b1;
    end

    drive(1'b0, '0, '0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/eq_result_checker.md
Name: eq_result_checker

Overview:
- Downstream consumer of the 16-bit equality comparator stage.
- Accepts a stream of operand pairs (a, b) together with the comparator's 1-bit equality output.
- Recomputes the golden a==b, then counts samples, equal results and disagreements.
- Captures the first failing beat and optionally halts the stream.
- Synthesizable replacement for the ad-hoc behavioural checker used in comparator regression.

Parameters:
- W, 16, operand width.
- CNT_W, 32, width of all statistic counters.
- WARMUP, 2, cycles after reset or clear during which beats are accepted but not checked.
- HALT_ON_ERR, 1, 1 = enter HALTED on the first disagreement; 0 = keep running.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear: statistics to zero, FSM to WARM.
- in_valid  in  1  beat present.
- in_ready  out  1  checker accepts a beat this cycle.
- in_a  in  W  operand a.
- in_b  in  W  operand b.
- in_eq  in  1  comparator-under-test result for (in_a, in_b).
- sample_cnt  out  CNT_W  checked beats.
- eq_cnt  out  CNT_W  checked beats where golden a==b.
- err_cnt  out  CNT_W  checked beats where in_eq != golden.
- err_flag  out  1  sticky; set on the first error.
- first_err_a  out  W  in_a of the first error.
- first_err_b  out  W  in_b of the first error.
- first_err_got  out  1  in_eq of the first error.
- halted  out  1  FSM in HALTED.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All counters and capture registers 0.
  - err_flag = 0, halted = 0.
  - FSM = WARM with warm-up counter = 0.
  - in_ready = 0 while rst_n is low.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - in_ready = (state != HALTED) && !clear. It is combinational from state and clear only, never from in_valid.
- FSM states:
  - WARM: each cycle, the warm-up counter increments. Accepted beats are dropped unchecked. When the counter reaches WARMUP-1, go to RUN. If WARMUP == 0, go straight to RUN after reset.
  - RUN: accepted beats are checked. On an error with HALT_ON_ERR == 1, go to HALTED.
  - HALTED: in_ready = 0. Only clear or rst_n exits, both to WARM.
- Checking (RUN, accepted beat):
  - golden = (in_a == in_b).
  - sample_cnt += 1.
  - eq_cnt += golden.
  - If in_eq != golden: err_cnt += 1. If err_flag == 0, also capture in_a, in_b and in_eq into the first_err_* registers and set err_flag.
- Latency: all statistics are registered and visible the cycle after the accepting edge. halted asserts in that same cycle.
- Counters saturate at 2^CNT_W-1 and never wrap. err_flag still sets when err_cnt is saturated.
- Simultaneous events:
  - clear and in_valid in the same cycle: clear wins and the beat is not accepted.
  - clear is ignored while rst_n is low.
- Reset mid-stream: any in-flight beat is discarded and no partial update occurs.
- X or Z on in_eq is a simulation-only concern. RTL compares with plain inequality, so the bench must drive only 0/1.

Optional Feature:
- Macro: EQ_CHECK_RUNLEN_EN.
- When defined, two extra output ports are added:
  - run_len (CNT_W): current consecutive count of golden-equal checked beats. Resets to 0 on a golden-unequal beat or on clear.
  - max_run_len (CNT_W): highest run_len seen since reset or clear.
- Both update with the same one-cycle latency as the other statistics and both saturate.
- When the macro is undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package eq_check_pkg holds:
  - typedef state_t {WARM, RUN, HALTED}.
  - Constants for default W and CNT_W.
  - A saturating-increment function used by every counter.
- One natural sub-module, sat_counter (parameter width, inputs inc and clr, output count). It is instantiated for sample, eq and err counts, and for the run-length counters when the macro is defined.

Test Plan:
- Reset/warm-up: WARMUP=2, drive 2 beats immediately after rst_n rises -> sample_cnt stays 0; third beat -> sample_cnt=1 the next cycle.
- Clean stream: 1000 beats with in_eq driven from a correct model, 25% with a==b -> err_cnt=0, err_flag=0, eq_cnt equals the model's count, sample_cnt=1000.
- Injected error: beat a=16'h00FF, b=16'h00FF, in_eq=0 -> next cycle err_cnt=1, first_err_a=16'h00FF, first_err_got=0, halted=1, in_ready=0.
- HALT_ON_ERR=0 with 3 injected errors -> err_cnt=3 and first_err_* hold the first one; a clear then zeroes everything and returns the FSM to WARM.
- clear asserted together with in_valid -> beat not accepted and counters 0. Saturation: CNT_W=4, 20 beats -> sample_cnt=15.
- EQ_CHECK_RUNLEN_EN defined: 5 equal beats, 1 unequal, 3 equal -> run_len=3, max_run_len=5.
